// File: rtl/multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_arbiter
// Purpose  : Round-robin arbiter and sequencer sharing one DATA_W x DATA_W
//            multiplier between two requesters. It accepts one operand pair
//            through a valid/ready handshake, pulses mul_start for one cycle,
//            waits for mul_done under a watchdog, then returns the product
//            tagged with the requester id through a valid/ready response
//            handshake. Only one multiplication is in flight at a time.
// Ports    : clk, reset_a (async, active-low)
//            req0_* / req1_*  : requester valid/ready with operands a, b
//            mul_*            : multiplier start, operands, done, product
//            rsp_*            : response valid/ready, data, id, error flag
//            busy, state_out  : status (IDLE=00 ISSUE=01 WAIT=10 RESP=11)
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_a,
    input  logic                req0_valid,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                req1_ready,
    output logic                mul_start,
    output logic [DATA_W-1:0]   mul_dataa,
    output logic [DATA_W-1:0]   mul_datab,
    input  logic                mul_done,
    input  logic [2*DATA_W-1:0] mul_product,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_id,
    output logic                rsp_err,
    output logic                busy,
    output logic [1:0]          state_out
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_ISSUE = 2'b01;
    localparam logic [1:0] c_WAIT  = 2'b10;
    localparam logic [1:0] c_RESP  = 2'b11;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic                r_ptr;
    logic                r_id;
    logic [DATA_W-1:0]   r_dataa;
    logic [DATA_W-1:0]   r_datab;
    logic [2*DATA_W-1:0] r_rsp_data;
    logic                r_rsp_id;
    logic                r_rsp_err;
    logic [c_CNT_W-1:0]  r_cnt;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;

    // A lone requester always wins; on contention the pointer decides.
    // The two grants are mutually exclusive by construction.
    assign w_idle   = (r_state == c_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || (r_ptr == 1'b0));
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || (r_ptr == 1'b1));

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign mul_start  = (r_state == c_ISSUE);
    assign mul_dataa  = r_dataa;
    assign mul_datab  = r_datab;
    assign rsp_valid  = (r_state == c_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;
    assign busy       = !w_idle;
    assign state_out  = r_state;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_state    <= c_IDLE;
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_dataa    <= '0;
            r_datab    <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_dataa <= w_grant1 ? req1_a : req0_a;
                        r_datab <= w_grant1 ? req1_b : req0_b;
                        r_id    <= w_grant1;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // A done arriving on the last permitted cycle beats the
                    // watchdog, so it is tested first.
                    if (mul_done) begin
                        r_rsp_data <= mul_product;
                        r_rsp_err  <= 1'b0;
                        r_rsp_id   <= r_id;
                        r_state    <= c_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_rsp_id   <= r_id;
                        r_state    <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_ptr   <= ~r_rsp_id;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
